// File: rtl/cpu_pkg.sv
// Shared definitions for the execution controller and its ALU: opcodes,
// controller state encoding and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SHIFT = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_NOP   = 4'b0111;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 9;
    localparam int RS1_MSB    = 8;
    localparam int RS1_LSB    = 6;
    localparam int RS2_MSB    = 5;
    localparam int RS2_LSB    = 3;
    localparam int DIR_BIT    = 2;
    localparam int IMM_MSB    = 5;
    localparam int IMM_LSB    = 0;
    localparam int BR_RS1_MSB = 11;
    localparam int BR_RS1_LSB = 9;
    localparam int BR_RS2_MSB = 8;
    localparam int BR_RS2_LSB = 6;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    function automatic logic [7:0] sext6(input logic [5:0] v);
        return {{2{v[5]}}, v};
    endfunction

    // ALU ops 0000-0110 and ADDI produce a register result
    function automatic logic writes_rd(input logic [3:0] op);
        return (op <= OP_SLT) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Instruction fetch and ALU signals between the controller (master) and the
// memory/ALU side (slave).
interface exec_ctrl_if;
    logic              imem_req;
    logic [7:0]        imem_addr;
    logic              imem_valid;
    logic [15:0]       imem_data;
    logic signed [7:0] alu_a;
    logic signed [7:0] alu_b;
    logic [3:0]        alu_opcode;
    logic              alu_dir;
    logic signed [7:0] alu_result;
    logic              alu_zero;
    logic              alu_branch_taken;

    modport master (
        output imem_req, imem_addr, alu_a, alu_b, alu_opcode, alu_dir,
        input  imem_valid, imem_data, alu_result, alu_zero, alu_branch_taken
    );

    modport slave (
        input  imem_req, imem_addr, alu_a, alu_b, alu_opcode, alu_dir,
        output imem_valid, imem_data, alu_result, alu_zero, alu_branch_taken
    );
endinterface

// File: rtl/reg_file_8x8.sv
// 8 x 8-bit register file, two combinational read ports, one synchronous
// write port. r0 is hard-wired to zero.
module reg_file_8x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] ra1,
    input  logic [2:0] ra2,
    output logic [7:0] rd1,
    output logic [7:0] rd2,
    input  logic       we,
    input  logic [2:0] wa,
    input  logic [7:0] wd
);
    logic [7:0] regs [8];

    // synchronous clear; writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we && (wa != 3'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 3'd0) ? 8'h00 : regs[ra1];
    assign rd2 = (ra2 == 3'd0) ? 8'h00 : regs[ra2];
endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle instruction sequencer driving an external instruction memory
// and combinational ALU.
//
// state  | meaning
// FETCH  | request word at pc, wait for imem_valid
// DECODE | read operands from the register file
// EXEC   | drive the ALU, capture result and branch decision
// WB     | write rd, advance pc, pulse retire
// HALT   | parked until reset
module exec_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    exec_ctrl_if.master bus,
    output logic [7:0] pc,
    output logic       halted,
    output logic       retire
);
    state_t      state_q, state_d;
    logic [15:0] instr_q;
    logic [7:0]  opa_q, opb_q, result_q, pc_q, pc_next;
    logic        dir_q, taken_q;
    logic [3:0]  opcode;
    logic        is_branch, is_rtype;
    logic [2:0]  rf_ra1, rf_ra2;
    logic [7:0]  rf_rd1, rf_rd2;
    logic        rf_we;

    // zero flag is only of interest to debug probes
    logic unused_alu_zero;
    assign unused_alu_zero = bus.alu_zero;

    assign opcode    = instr_q[OPC_MSB:OPC_LSB];
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_rtype  = (opcode <= OP_SLT);
    assign rf_ra1    = is_branch ? instr_q[BR_RS1_MSB:BR_RS1_LSB] : instr_q[RS1_MSB:RS1_LSB];
    assign rf_ra2    = is_branch ? instr_q[BR_RS2_MSB:BR_RS2_LSB] : instr_q[RS2_MSB:RS2_LSB];
    assign rf_we     = rst_n && (state_q == ST_WB) && writes_rd(opcode);
    assign pc_next   = pc_q + 8'd1 +
                       ((is_branch && taken_q) ? sext6(instr_q[IMM_MSB:IMM_LSB]) : 8'd0);

    reg_file_8x8 u_rf (
        .clk (clk),
        .rst_n (rst_n),
        .ra1 (rf_ra1),
        .ra2 (rf_ra2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (instr_q[RD_MSB:RD_LSB]),
        .wd  (result_q)
    );

    // state register plus per-state datapath captures
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_FETCH: if (bus.imem_valid) instr_q <= bus.imem_data;
                ST_DECODE: begin
                    // a HALT leaves the operands untouched so the ALU inputs hold
                    if (opcode != OP_HALT) begin
                        opa_q <= rf_rd1;
                        opb_q <= (opcode == OP_ADDI) ? sext6(instr_q[IMM_MSB:IMM_LSB]) : rf_rd2;
                        dir_q <= is_rtype ? instr_q[DIR_BIT] : 1'b0;
                    end
                end
                ST_EXEC: begin
                    result_q <= bus.alu_result;
                    taken_q  <= bus.alu_branch_taken;
                end
                ST_WB:   pc_q <= pc_next;
                default: ;
            endcase
        end
    end

    // next-state and state-decoded outputs; held low while reset is asserted
    always_comb begin
        state_d        = state_q;
        bus.imem_req   = 1'b0;
        bus.alu_opcode = OP_NOP;
        halted         = 1'b0;
        retire         = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus.imem_req = rst_n;
                if (bus.imem_valid) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (rst_n) bus.alu_opcode = opcode;
                state_d = ST_WB;
            end
            ST_WB: begin
                retire  = rst_n;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = rst_n;
                if (rst_n) bus.alu_opcode = OP_ADD;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.alu_a     = opa_q;
    assign bus.alu_b     = opb_q;
    assign bus.alu_dir   = dir_q;
    assign pc            = pc_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: stand-in ALU, program table with a scoreboard of
// expected retire results, plus hand sequences for reset/halt/wrap cases.
module tb_exec_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc;
    logic       halted, retire;

    exec_ctrl_if bus ();

    exec_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc     (pc),
        .halted (halted),
        .retire (retire)
    );

    always #5 clk = ~clk;

    logic signed [7:0] alu_res;
    logic              alu_tk;

    // stand-in ALU
    always_comb begin
        case (bus.alu_opcode)
            OP_ADD, OP_ADDI: alu_res = bus.alu_a + bus.alu_b;
            OP_SUB:   alu_res = bus.alu_a - bus.alu_b;
            OP_AND:   alu_res = bus.alu_a & bus.alu_b;
            OP_OR:    alu_res = bus.alu_a | bus.alu_b;
            OP_XOR:   alu_res = bus.alu_a ^ bus.alu_b;
            OP_SHIFT: alu_res = bus.alu_dir ? (bus.alu_a >>> bus.alu_b[2:0]) : (bus.alu_a << bus.alu_b[2:0]);
            OP_SLT:   alu_res = (bus.alu_a < bus.alu_b) ? 8'sd1 : 8'sd0;
            OP_NOP:   alu_res = 8'sd0;
            default:  alu_res = bus.alu_a ^ 8'sh5A;
        endcase
        if (bus.alu_opcode == OP_BEQ)      alu_tk = (bus.alu_a == bus.alu_b);
        else if (bus.alu_opcode == OP_BNE) alu_tk = (bus.alu_a != bus.alu_b);
        else                               alu_tk = 1'b0;
    end

    assign bus.alu_result       = alu_res;
    assign bus.alu_zero         = (alu_res == 8'sd0);
    assign bus.alu_branch_taken = alu_tk;

    typedef struct {
        logic [15:0] instr;
        int          waits;
        bit          stray;
        logic [7:0]  exp_pc;
        logic [2:0]  chk_reg;
        logic [7:0]  exp_val;
    } vec_t;

    vec_t       exp_q[$];
    vec_t       tbl[12];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] pc_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        pc_model = 8'h00;
    endtask

    // Entered at a FETCH-cycle negedge; returns at the next FETCH negedge.
    task automatic run_instr(input string tag, input vec_t v);
        vec_t e;
        int   lat;
        bit   req_ok;
        exp_q.push_back(v);
        lat = 0;
        while (!bus.imem_req && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " fetch_addr"}, bus.imem_addr, pc_model);
        check({tag, " idle_opcode"}, bus.alu_opcode, OP_NOP);
        lat    = 1;
        req_ok = 1'b1;
        repeat (v.waits) begin
            @(negedge clk);
            lat++;
            if (bus.imem_req !== 1'b1) req_ok = 1'b0;
        end
        bus.imem_valid = 1'b1;
        bus.imem_data  = v.instr;
        @(negedge clk);
        lat++;
        bus.imem_valid = v.stray;
        bus.imem_data  = 16'hF000;
        @(negedge clk);
        lat++;
        bus.imem_valid = 1'b0;
        check({tag, " exec_opcode"}, bus.alu_opcode, v.instr[15:12]);
        while (retire !== 1'b1 && lat < v.waits + 20) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        check({tag, " latency"}, lat, 4 + e.waits);
        if (e.waits > 0) check({tag, " req_held"}, req_ok, 1);
        @(negedge clk);
        check({tag, " pc"}, pc, e.exp_pc);
        check({tag, " reg"}, dut.u_rf.regs[e.chk_reg], e.exp_val);
        pc_model = e.exp_pc;
    endtask

    initial begin
        int hold_bad;
        rst_n          = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_data  = 16'h0000;
        pc_model       = 8'h00;

        tbl[0]  = '{16'h9205, 0, 1'b0, 8'd1,  3'd1, 8'h05};  // ADDI r1,r0,5
        tbl[1]  = '{16'h943D, 0, 1'b0, 8'd2,  3'd2, 8'hFD};  // ADDI r2,r0,-3
        tbl[2]  = '{16'h0650, 0, 1'b0, 8'd3,  3'd3, 8'h02};  // ADD r3,r1,r2
        tbl[3]  = '{16'h5848, 0, 1'b0, 8'd4,  3'd4, 8'hA0};  // SHIFT r4,r1,r1 left
        tbl[4]  = '{16'hA840, 0, 1'b0, 8'd5,  3'd4, 8'hA0};  // opcode 1010 as NOP, rd=r4
        tbl[5]  = '{16'h9007, 0, 1'b0, 8'd6,  3'd0, 8'h00};  // ADDI r0,r0,7
        tbl[6]  = '{16'h9A01, 3, 1'b1, 8'd7,  3'd5, 8'h01};  // ADDI r5 after 3 wait cycles
        tbl[7]  = '{16'hC243, 0, 1'b0, 8'd8,  3'd1, 8'h05};  // BNE r1,r1 not taken
        tbl[8]  = '{16'hB281, 0, 1'b0, 8'd9,  3'd2, 8'hFD};  // BEQ r1,r2 not taken
        tbl[9]  = '{16'h7000, 0, 1'b0, 8'd10, 3'd3, 8'h02};  // NOP
        tbl[10] = '{16'hB27E, 0, 1'b0, 8'd9,  3'd1, 8'h05};  // BEQ r1,r1,-2 at pc 10
        tbl[11] = '{16'hC285, 0, 1'b0, 8'd15, 3'd5, 8'h01};  // BNE r1,r2,+5 taken

        // reset values
        repeat (2) @(negedge clk);
        check("rst imem_req", bus.imem_req, 0);
        check("rst halted", halted, 0);
        check("rst retire", retire, 0);
        check("rst alu_opcode", bus.alu_opcode, OP_NOP);
        check("rst alu_a", bus.alu_a, 0);
        check("rst alu_b", bus.alu_b, 0);
        check("rst alu_dir", bus.alu_dir, 0);
        check("rst pc", pc, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst imem_req", bus.imem_req, 1);
        check("post_rst imem_addr", bus.imem_addr, 0);

        for (int i = 0; i < 12; i++) run_instr($sformatf("row%0d", i), tbl[i]);
        check("exp_q empty", exp_q.size(), 0);

        // reset while ADD r3 is in EXEC
        @(negedge clk);
        do_reset();
        run_instr("rx0", '{16'h9205, 0, 1'b0, 8'd1, 3'd1, 8'h05});
        run_instr("rx1", '{16'h943D, 0, 1'b0, 8'd2, 3'd2, 8'hFD});
        bus.imem_valid = 1'b1;
        bus.imem_data  = 16'h0650;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        @(negedge clk);
        check("rx exec_opcode", bus.alu_opcode, OP_ADD);
        do_reset();
        check("rx retire", retire, 0);
        check("rx pc", pc, 0);
        check("rx r3", dut.u_rf.regs[3], 0);
        check("rx r1 cleared", dut.u_rf.regs[1], 0);
        check("rx fetch req", bus.imem_req, 1);
        check("rx fetch addr", bus.imem_addr, 0);

        // HALT at pc 4, parked for 20 cycles, then reset
        for (int i = 0; i < 4; i++)
            run_instr($sformatf("hn%0d", i), '{16'h7000, 0, 1'b0, 8'(i + 1), 3'd0, 8'h00});
        bus.imem_valid = 1'b1;
        bus.imem_data  = 16'hF000;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.imem_valid = (c >= 5 && c < 8);
            bus.imem_data  = 16'h9205;
            if (!(halted === 1'b1 && bus.imem_req === 1'b0 && pc === 8'd4 &&
                  retire === 1'b0 && bus.alu_opcode === OP_ADD)) hold_bad++;
        end
        bus.imem_valid = 1'b0;
        check("halt hold_bad_cycles", hold_bad, 0);
        check("halt halted", halted, 1);
        check("halt r1 untouched", dut.u_rf.regs[1], 0);
        do_reset();
        check("unhalt pc", pc, 0);
        check("unhalt halted", halted, 0);
        check("unhalt imem_req", bus.imem_req, 1);

        // pc wrap both ways: 0 -> FF with off -2, FF -> 01 with off +1
        run_instr("wrap0", '{16'hB03E, 0, 1'b0, 8'hFF, 3'd0, 8'h00});
        run_instr("wrap1", '{16'hB001, 0, 1'b0, 8'h01, 3'd0, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
